// File: rtl/keyboard_pkg.sv
// Shared constants for the PS/2 scan-code sequencer: prefix bytes, filtered
// bytes, key_status bit positions, queue entry width and decoder state encoding.
package keyboard_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam logic [7:0] PS2_ERR0    = 8'h00;
   localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
   localparam logic [7:0] PS2_ECHO    = 8'hEE;
   localparam logic [7:0] PS2_ACK     = 8'hFA;
   localparam logic [7:0] PS2_BAT_ERR = 8'hFC;
   localparam logic [7:0] PS2_RESEND  = 8'hFE;
   localparam logic [7:0] PS2_ERR1    = 8'hFF;

   localparam int KS_BREAK = 0;
   localparam int KS_AVAIL = 1;
   localparam int KS_EXT   = 2;
   localparam int KS_OVF   = 3;

   // Entry layout: [9] extended, [8] break, [7:0] scan code.
   localparam int ENTRY_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXT    = 2'd1,
      ST_BRK    = 2'd2,
      ST_EXTBRK = 2'd3
   } scan_state_t;

   // Controller responses and error codes that never describe a key.
   function automatic logic is_filtered(input logic [7:0] b);
      case (b)
         PS2_ERR0, PS2_BAT_OK, PS2_ECHO, PS2_ACK,
         PS2_BAT_ERR, PS2_RESEND, PS2_ERR1: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/scan_fifo.sv
// Circular key-event queue with extra-bit pointers; head is read combinationally
// so a push is visible the cycle after it is accepted.
module scan_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [W-1:0]      push_data,
   input  logic              pop,
   output logic [W-1:0]      head,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   logic [W-1:0]    mem [DEPTH];
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic            pop_ok;
   logic            push_ok;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (ADDR_W+1)'(DEPTH));
   assign empty = (count == '0);

   // A pop on an empty queue is ignored; a push into a full queue only lands
   // when the head is retired in the same cycle.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
   end

   assign head = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/keyboard_scan_queue.sv
// Strips E0/F0 prefixes from the PS/2 byte stream, queues complete key events
// and presents the queue head as key_status/keycode for the READKEY path.
module keyboard_scan_queue
   import keyboard_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_valid,
   input  logic [7:0]        scan_byte,
   input  logic              pop,
   output logic [7:0]        key_status,
   output logic [7:0]        keycode,
   output logic [ADDR_W:0]   count
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   scan_state_t        state;
   logic [TMR_W-1:0]   timer;
   logic               overflow;
   logic               push;
   logic [ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               seen_ext;
   logic               seen_brk;

   assign seen_ext = (state == ST_EXT) || (state == ST_EXTBRK);
   assign seen_brk = (state == ST_BRK) || (state == ST_EXTBRK);

   always_comb begin
      push      = 1'b0;
      push_data = {seen_ext, seen_brk, scan_byte};
      if (scan_valid && scan_byte != PS2_EXT && scan_byte != PS2_BRK &&
          !is_filtered(scan_byte))
         push = 1'b1;
   end

   // Prefix flags accumulate until a code byte or a filtered byte ends the event;
   // a prefix left waiting too long is abandoned without emitting anything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         timer <= '0;
      end else if (scan_valid) begin
         timer <= '0;
         if (scan_byte == PS2_EXT)
            state <= seen_brk ? ST_EXTBRK : ST_EXT;
         else if (scan_byte == PS2_BRK)
            state <= seen_ext ? ST_EXTBRK : ST_BRK;
         else
            state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
         timer <= '0;
      end else if (timer == TMR_W'(TIMEOUT - 1)) begin
         state <= ST_IDLE;
         timer <= '0;
      end else begin
         timer <= timer + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (pop && !fifo_empty)
         overflow <= 1'b0;
      else if (push && fifo_full)
         overflow <= 1'b1;
   end

   scan_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .W      (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   always_comb begin
      key_status           = '0;
      keycode              = '0;
      key_status[KS_OVF]   = overflow;
      key_status[KS_AVAIL] = !fifo_empty;
      if (!fifo_empty) begin
         key_status[KS_EXT]   = head[9];
         key_status[KS_BREAK] = head[8];
         keycode              = head[7:0];
      end
   end

endmodule
